// File: rtl/fp12_accumulator.sv
// Sequential FP12 accumulator: IDLE -> ALIGN -> ADD -> NORM per term, result held in DONE.
// Optional sticky overflow/underflow flag port acc_ovf is enabled by FP12_ACC_OVF_FLAG_EN.
module fp12_accumulator #(
    parameter int EW = 4,
    parameter int MW = 7,
    parameter int GW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [EW+MW:0]  in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [EW+MW:0]  out_data,
    output logic            out_valid,
    input  logic            out_ready
`ifdef FP12_ACC_OVF_FLAG_EN
    ,
    output logic            acc_ovf
`endif
);
    // The exponent bias cancels out of an addition, so it never appears below.
    localparam int W     = 1 + EW + MW;
    localparam int MAN_W = MW + GW + 1;
    localparam int SUM_W = MW + GW + 2;
    localparam int EMAX  = (1 << EW) - 1;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       op_q, op_d;
    logic               last_q, last_d;
    logic               a_sign_q, a_sign_d;
    logic [EW-1:0]      a_exp_q, a_exp_d;
    logic [MAN_W-1:0]   a_man_q, a_man_d;
    logic [MAN_W-1:0]   b_man_q, b_man_d;
    logic               sub_q, sub_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;

    // Alignment datapath: zero operands get an all-zero mantissa so they sort below everything.
    logic [EW-1:0]      x_exp, y_exp, b_exp, exp_diff;
    logic [MAN_W-1:0]   x_man, y_man, b_man;
    logic               swap;

    always_comb begin
        x_exp    = acc_q[W-2:MW];
        y_exp    = op_q[W-2:MW];
        x_man    = (x_exp == '0) ? '0 : {1'b1, acc_q[MW-1:0], {GW{1'b0}}};
        y_man    = (y_exp == '0) ? '0 : {1'b1, op_q[MW-1:0], {GW{1'b0}}};
        swap     = {y_exp, y_man} > {x_exp, x_man};
        a_sign_d = swap ? op_q[W-1] : acc_q[W-1];
        a_exp_d  = swap ? y_exp : x_exp;
        a_man_d  = swap ? y_man : x_man;
        b_exp    = swap ? x_exp : y_exp;
        b_man    = swap ? x_man : y_man;
        exp_diff = a_exp_d - b_exp;
        b_man_d  = (int'(exp_diff) >= MAN_W) ? '0 : (b_man >> exp_diff);
        sub_d    = acc_q[W-1] ^ op_q[W-1];
    end

    // Normalisation: leading-one detect, exponent adjust, truncate guard bits, clamp range.
    int                 lead;
    int                 lz;
    int                 e_norm;
    logic [SUM_W-1:0]   shifted;
    logic [MW-1:0]      n_man;
    logic [W-1:0]       norm_word;
    logic               norm_ovf;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        lead      = 0;
        lz        = 0;
        shifted   = '0;
        n_man     = '0;
        e_norm    = 0;
        norm_word = '0;
        norm_ovf  = 1'b0;
        for (int i = 0; i < SUM_W - 1; i++) begin
            if (sum_q[i]) lead = i;
        end
        if (sum_q[SUM_W-1]) begin
            e_norm = int'(a_exp_q) + 1;
            n_man  = sum_q[MAN_W-1 -: MW];
        end else begin
            lz      = (MAN_W - 1) - lead;
            shifted = sum_q << lz;
            e_norm  = int'(a_exp_q) - lz;
            n_man   = shifted[MAN_W-2 -: MW];
        end
        if (sum_q == '0) begin
            norm_word = '0;
        end else if (e_norm > EMAX) begin
            norm_word = {a_sign_q, {EW{1'b1}}, {MW{1'b1}}};
            norm_ovf  = 1'b1;
        end else if (e_norm < 1) begin
            norm_word = '0;
            norm_ovf  = 1'b1;
        end else begin
            norm_word = {a_sign_q, EW'(e_norm), n_man};
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        last_d  = last_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                op_d    = in_data;
                last_d  = in_last;
                state_d = ALIGN;
            end
            ALIGN: state_d = ADD;
            ADD: begin
                sum_d   = sub_q ? ({1'b0, a_man_q} - {1'b0, b_man_q})
                                : ({1'b0, a_man_q} + {1'b0, b_man_q});
                state_d = NORM;
            end
            NORM: begin
                acc_d   = norm_word;
                ovf_d   = ovf_q | norm_ovf;
                state_d = last_q ? DONE : IDLE;
            end
            DONE: if (out_ready) begin
                acc_d   = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            op_q     <= '0;
            last_q   <= 1'b0;
            a_sign_q <= 1'b0;
            a_exp_q  <= '0;
            a_man_q  <= '0;
            b_man_q  <= '0;
            sub_q    <= 1'b0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            if (state_q == ALIGN) begin
                a_sign_q <= a_sign_d;
                a_exp_q  <= a_exp_d;
                a_man_q  <= a_man_d;
                b_man_q  <= b_man_d;
                sub_q    <= sub_d;
            end
        end
    end

    // in_ready is gated by rst_n so it stays low for the whole reset pulse.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign out_data  = (state_q == DONE) ? acc_q : '0;

`ifdef FP12_ACC_OVF_FLAG_EN
    assign acc_ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule
